write_ram_mem: RTL

Writes a 32-byte block from a parallel register array into single-port on-chip RAM, one byte per address, starting at address 0. It can optionally read back and verify each byte. It is the write-side counterpart to the ROM block-reader: the reader fills a byte array from memory, and this block drains a byte array (for example, a decrypted message) into the message RAM for inspection via the in-system memory editor. A parent FSM pulses `start`, waits for `done`, then samples `error`.

---
 rtl/write_ram_mem.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/write_ram_mem.sv
// Purpose : drains a DEPTH-byte register array into single-port RAM at addresses 0..DEPTH-1,
//           optionally reading each byte back and flagging the first mismatching address.
// Latency : VERIFY=1 -> 3 cycles per byte (WRITE, READ, CHECK), done at start edge + 3*DEPTH;
//           VERIFY=0 -> 1 cycle per byte, done at start edge + DEPTH.
// Backpr. : none; start is accepted only in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            run request, sampled in IDLE/DONE only
//   data_in[DEPTH]   source bytes, captured on the accepting edge (don't-care afterwards)
//   ram_q            RAM read data (registered-address read, 1-cycle latency)
//   address/ram_data/wren   RAM write port (address also drives the read)
//   busy/done        run in progress / run finished (done is a level held until restart)
//   error/bad_addr   sticky readback mismatch flag and address of the first mismatch
module write_ram_mem #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter bit VERIFY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        data_in [DEPTH],
    input  logic [7:0]        ram_q,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        ram_data,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] bad_addr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [7:0]        snap_q [DEPTH];
    logic [ADDR_W-1:0] address_q;
    logic [ADDR_W-1:0] bad_addr_q;
    logic [7:0]        ram_data_q;
    logic              wren_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    // Index of the following byte; only used when idx_q is below LAST_IDX, so it never wraps.
    assign idx_d = idx_q + ADDR_W'(1);

    // All outputs are registered and loaded one edge ahead of the state they belong to,
    // so WRITE of byte i already presents address/data/wren on the cycle it occupies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            address_q  <= '0;
            ram_data_q <= '0;
            wren_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        snap_q     <= data_in;
                        idx_q      <= '0;
                        address_q  <= '0;
                        ram_data_q <= data_in[0];
                        wren_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        bad_addr_q <= '0;
                        state_q    <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (VERIFY) begin
                        // Address stays on idx_q so the RAM captures it as the read address.
                        wren_q  <= 1'b0;
                        state_q <= ST_READ;
                    end else if (idx_q == LAST_IDX) begin
                        wren_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q      <= idx_d;
                        address_q  <= idx_d;
                        ram_data_q <= snap_q[idx_d];
                        wren_q     <= 1'b1;
                    end
                end

                ST_READ: begin
                    state_q <= ST_CHECK;
                end

                ST_CHECK: begin
                    // Only the first mismatch of a run is recorded.
                    if ((ram_q != snap_q[idx_q]) && !error_q) begin
                        error_q    <= 1'b1;
                        bad_addr_q <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q      <= idx_d;
                        address_q  <= idx_d;
                        ram_data_q <= snap_q[idx_d];
                        wren_q     <= 1'b1;
                        state_q    <= ST_WRITE;
                    end
                end

                default: begin
                    wren_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign address  = address_q;
    assign ram_data = ram_data_q;
    assign wren     = wren_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign bad_addr = bad_addr_q;

endmodule
